// File: rtl/cascade_counter_pkg.sv
// cascade_counter_pkg: shared end-of-chain mode type for cascade counters and raster FSMs
package cascade_counter_pkg;
  typedef enum logic {WRAP, SATURATE} end_mode_t;
endpackage

// File: rtl/cascade_stage.sv
// cascade_stage: combinational terminal decode and next value for one counter stage
// ports: count, rollover_val, count_down, advance -> terminal, next_count
module cascade_stage #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic [NUM_CNT_BITS-1:0] count,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  input  logic                    count_down,
  input  logic                    advance,
  output logic                    terminal,
  output logic [NUM_CNT_BITS-1:0] next_count
);
  // >= so an out-of-range loaded value wraps to 0 on the next up advance
  assign terminal   = count_down ? (count == '0) : (count >= rollover_val);
  assign next_count = !advance ? count :
                      terminal ? (count_down ? rollover_val : '0) :
                      count_down ? count - 1'b1 : count + 1'b1;
endmodule

// File: rtl/cascade_counter.sv
// cascade_counter: chain of up/down stages, each advancing when all lower stages are terminal
// ports: clk, n_rst, clear, load/load_val, count_enable, count_down, end_mode, rollover_val
//        -> count_out, stage_terminal, all_terminal, wrap_pulse
module cascade_counter
  import cascade_counter_pkg::*;
#(
  parameter int NUM_STAGES   = 2,
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                               clk,
  input  logic                               n_rst,
  input  logic                               clear,
  input  logic                               load,
  input  logic [NUM_STAGES*NUM_CNT_BITS-1:0] load_val,
  input  logic                               count_enable,
  input  logic                               count_down,
  input  end_mode_t                          end_mode,
  input  logic [NUM_STAGES*NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_STAGES*NUM_CNT_BITS-1:0] count_out,
  output logic [NUM_STAGES-1:0]              stage_terminal,
  output logic                               all_terminal,
  output logic                               wrap_pulse
);
  logic [NUM_STAGES*NUM_CNT_BITS-1:0] next_count;
  logic [NUM_STAGES-1:0]              advance;
  logic                               hold;
  logic                               carry;
  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    cascade_stage #(.NUM_CNT_BITS(NUM_CNT_BITS)) u_stage (
      .count        (count_out[g*NUM_CNT_BITS +: NUM_CNT_BITS]),
      .rollover_val (rollover_val[g*NUM_CNT_BITS +: NUM_CNT_BITS]),
      .count_down   (count_down),
      .advance      (advance[g]),
      .terminal     (stage_terminal[g]),
      .next_count   (next_count[g*NUM_CNT_BITS +: NUM_CNT_BITS])
    );
  end
  assign all_terminal = &stage_terminal;
  // a saturated chain freezes every stage rather than just the top one
  assign hold = all_terminal && (end_mode == SATURATE);
  always_comb begin
    carry   = 1'b1;
    advance = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      advance[k] = count_enable && carry && !hold;
      carry      = carry && stage_terminal[k];
    end
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out  <= '0;
      wrap_pulse <= 1'b0;
    end else if (clear) begin
      count_out  <= '0;
      wrap_pulse <= 1'b0;
    end else if (load) begin
      count_out  <= load_val;
      wrap_pulse <= 1'b0;
    end else begin
      count_out  <= next_count;
      wrap_pulse <= count_enable && all_terminal && (end_mode == WRAP);
    end
  end
endmodule

// File: tb/tb_cascade_counter.sv
// tb_cascade_counter: directed checks of the cascade counter with NUM_STAGES=2, NUM_CNT_BITS=4
module tb_cascade_counter;
  import cascade_counter_pkg::*;
  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic       count_enable = 1'b0;
  logic       count_down = 1'b0;
  end_mode_t  end_mode = WRAP;
  logic [7:0] rollover_val = 8'h23;
  logic [7:0] count_out;
  logic [1:0] stage_terminal;
  logic       all_terminal;
  logic       wrap_pulse;
  int checks = 0;
  int failures = 0;
  cascade_counter #(.NUM_STAGES(2), .NUM_CNT_BITS(4)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .clear          (clear),
    .load           (load),
    .load_val       (load_val),
    .count_enable   (count_enable),
    .count_down     (count_down),
    .end_mode       (end_mode),
    .rollover_val   (rollover_val),
    .count_out      (count_out),
    .stage_terminal (stage_terminal),
    .all_terminal   (all_terminal),
    .wrap_pulse     (wrap_pulse)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    #2;
    chk("rst_count", 32'(count_out), 32'h00);
    chk("rst_wrap", 32'(wrap_pulse), 32'h0);
    chk("rst_term_up", 32'(stage_terminal), 32'h0);
    count_down = 1'b1;
    #1;
    chk("rst_term_down", 32'(stage_terminal), 32'h3);
    count_down = 1'b0;
    tick();
    n_rst = 1'b1;
    count_enable = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    chk("up_wrap_11", 32'(count_out), 32'h23);
    chk("up_wrap_11_allterm", 32'(all_terminal), 32'h1);
    chk("up_wrap_11_nopulse", 32'(wrap_pulse), 32'h0);
    tick();
    count_enable = 1'b0;
    chk("up_wrap_12", 32'(count_out), 32'h00);
    chk("up_wrap_pulse", 32'(wrap_pulse), 32'h1);
    tick();
    chk("up_wrap_pulse_drop", 32'(wrap_pulse), 32'h0);
    end_mode = SATURATE;
    count_enable = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("sat_nopulse", 32'(wrap_pulse), 32'h0);
    end
    chk("sat_hold", 32'(count_out), 32'h23);
    chk("sat_allterm", 32'(all_terminal), 32'h1);
    count_enable = 1'b0;
    end_mode = WRAP;
    count_down = 1'b1;
    load = 1'b1;
    load_val = 8'h10;
    tick();
    load = 1'b0;
    chk("down_load", 32'(count_out), 32'h10);
    count_enable = 1'b1;
    tick();
    chk("down_1", 32'(count_out), 32'h03);
    for (int i = 0; i < 3; i++) tick();
    chk("down_4", 32'(count_out), 32'h00);
    chk("down_4_allterm", 32'(all_terminal), 32'h1);
    tick();
    count_enable = 1'b0;
    chk("down_wrap", 32'(count_out), 32'h23);
    chk("down_wrap_pulse", 32'(wrap_pulse), 32'h1);
    tick();
    chk("down_wrap_pulse_drop", 32'(wrap_pulse), 32'h0);
    count_down = 1'b0;
    clear = 1'b1;
    load = 1'b1;
    load_val = 8'h12;
    count_enable = 1'b1;
    tick();
    clear = 1'b0;
    chk("prio_clear", 32'(count_out), 32'h00);
    tick();
    load = 1'b0;
    count_enable = 1'b0;
    chk("prio_load", 32'(count_out), 32'h12);
    load = 1'b1;
    load_val = 8'h19;
    tick();
    load = 1'b0;
    chk("oor_term", 32'(stage_terminal), 32'h1);
    count_enable = 1'b1;
    tick();
    count_enable = 1'b0;
    chk("oor_wrap", 32'(count_out), 32'h20);
    rollover_val = 8'h20;
    count_enable = 1'b1;
    tick();
    chk("zero_lim_0", 32'(count_out), 32'h00);
    chk("zero_lim_0_pulse", 32'(wrap_pulse), 32'h1);
    tick();
    chk("zero_lim_1", 32'(count_out), 32'h10);
    chk("zero_lim_1_nopulse", 32'(wrap_pulse), 32'h0);
    tick();
    chk("zero_lim_2", 32'(count_out), 32'h20);
    count_enable = 1'b0;
    rollover_val = 8'h23;
    load = 1'b1;
    load_val = 8'h12;
    tick();
    load = 1'b0;
    chk("arst_pre", 32'(count_out), 32'h12);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_count", 32'(count_out), 32'h00);
    chk("arst_wrap", 32'(wrap_pulse), 32'h0);
    #1;
    n_rst = 1'b1;
    count_enable = 1'b1;
    tick();
    count_enable = 1'b0;
    chk("arst_resume", 32'(count_out), 32'h01);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cascade_counter.md
# cascade_counter

Parametrised chain of NUM_STAGES flexible counters in which each stage advances only when all lower stages sit at their terminal value. Supports up/down counting, parallel load, and a wrap or saturate end-of-chain mode. It replaces hand-chained single counters in the edge-detector datapath: pixel column, row and frame counters, and window/tile position tracking.

## Interface
- NUM_STAGES, 2, number of cascaded stages; stage 0 is least significant
- NUM_CNT_BITS, 4, width of each stage
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear of all stages
- load  in  1  synchronous parallel load from load_val
- load_val  in  NUM_STAGES*NUM_CNT_BITS  packed load values; stage k occupies bits [k*NUM_CNT_BITS +: NUM_CNT_BITS]
- count_enable  in  1  advance the chain by one step
- count_down  in  1  0 = count up, 1 = count down
- end_mode  in  end_mode_t  WRAP or SATURATE
- rollover_val  in  NUM_STAGES*NUM_CNT_BITS  packed per-stage maximum value
- count_out  out  NUM_STAGES*NUM_CNT_BITS  registered stage values, same packing
- stage_terminal  out  NUM_STAGES  per-stage terminal decode
- all_terminal  out  1  AND of stage_terminal
- wrap_pulse  out  1  registered one-cycle pulse after a full-chain wrap

## Operation
- Each stage ranges 0..rollover_val[k].
- Terminal condition, up: count >= rollover_val[k]. Terminal condition, down: count == 0.
- stage_terminal and all_terminal decode combinationally from the count registers, rollover_val and count_down only. There is no path from count_enable, load or clear to these outputs.
- Stage k advances on a count cycle when k == 0 or stage_terminal[k-1:0] are all 1.
- Advance, up: terminal stage goes to 0; otherwise count+1.
- Advance, down: terminal stage goes to rollover_val[k]; otherwise count-1.
- A loaded value above rollover_val[k] is terminal in up mode, so the next advance wraps that stage to 0. In down mode it decrements normally.
- rollover_val[k] == 0: the stage is always terminal in either direction and holds 0.
- SATURATE: a count cycle with all_terminal = 1 leaves every stage unchanged. wrap_pulse stays 0.
- WRAP: a count cycle with all_terminal = 1 wraps every stage, and wrap_pulse is 1 for the following cycle only.
- Priority per edge: clear > load > count_enable.
  - clear: all stages 0, wrap_pulse 0.
  - load: all stages take load_val, no count, wrap_pulse 0.
- Direction, mode and rollover_val may change on any cycle. They take effect on the next edge with no pipeline.
- The block never generates X. All widths are fixed at NUM_CNT_BITS with no carry bit stored.

## Timing
- Reset (n_rst low, asynchronous): count_out = 0, wrap_pulse = 0.
  - stage_terminal after reset follows the decode: all 1 if count_down = 1; bit k = 1 only where rollover_val[k] == 0 if counting up.
- Count, load and clear latency is 1 cycle: the value is visible on count_out after the edge that samples the request.
- wrap_pulse asserts exactly the cycle after the wrapping edge.
- Back-to-back wraps are possible, e.g. all rollover_val = 0 in WRAP mode. In that case wrap_pulse stays high every enabled cycle.
- Reset asserted mid-count clears the chain and wrap_pulse immediately. Counting resumes on the first enabled edge after n_rst rises.

## Structure
- Package cascade_counter_pkg holds typedef enum logic {WRAP, SATURATE} end_mode_t. It is shared with the raster control FSMs.
- Sub-module cascade_stage, one per stage via generate. It is purely combinational:
  - inputs: count, rollover_val, count_down, advance
  - outputs: terminal, next_count
- The top level holds the count registers, the advance/carry chain, priority muxing and the wrap_pulse register.

## Test plan
All scenarios use NUM_STAGES = 2, NUM_CNT_BITS = 4, rollover_val = {2, 3} (stage1 = 2, stage0 = 3) unless stated.
- Up, WRAP: reset, then 11 enables -> count_out (s1,s0) = (2,3) and all_terminal = 1. The 12th enable -> (0,0), with wrap_pulse high for exactly one cycle.
- Up, SATURATE: 15 enables from reset -> holds at (2,3), all_terminal = 1, wrap_pulse never asserts.
- Down, WRAP:
  - load (1,0) then 1 enable -> (0,3).
  - 3 more enables -> (0,0), all_terminal = 1.
  - next enable -> (2,3) with a wrap_pulse.
- Priority:
  - clear + load + enable together -> (0,0).
  - load (1,2) + enable -> (1,2), not (1,3).
- Out-of-range and zero limit:
  - load s0 = 9 -> stage_terminal[0] = 1.
  - one up enable -> (s1+1, 0).
  - rollover_val stage0 = 0 -> s0 stays 0 and stage1 advances every enable.
- Async reset mid-count: at (1,2), pull n_rst low between edges -> count_out = 0 and wrap_pulse = 0 before the next edge. After release, one enable -> (0,1).
